// File: rtl/lsu_axil_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_axil_bridge
//  Description : Turns the single-cycle core's combinational data-memory
//                request into one AXI4-Lite read or write transaction and
//                stalls the core until the response has been captured.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_axil_bridge #(
   parameter int XLEN = 32   // only 32 is supported; strobe is fixed at 4 bits
) (
   input  logic            clk,
   input  logic            rst,
   // core side
   input  logic            data_valid,
   input  logic            data_wen,
   input  logic [3:0]      data_wstrb,
   input  logic [XLEN-1:0] data_addr,
   input  logic [XLEN-1:0] data_wdata,
   output logic [XLEN-1:0] data_rdata,
   output logic            data_stall,
   output logic            data_err,
   // AXI4-Lite master: write address
   output logic            m_awvalid,
   input  logic            m_awready,
   output logic [XLEN-1:0] m_awaddr,
   // write data
   output logic            m_wvalid,
   input  logic            m_wready,
   output logic [XLEN-1:0] m_wdata,
   output logic [3:0]      m_wstrb,
   // write response
   input  logic            m_bvalid,
   output logic            m_bready,
   input  logic [1:0]      m_bresp,
   // read address
   output logic            m_arvalid,
   input  logic            m_arready,
   output logic [XLEN-1:0] m_araddr,
   // read data
   input  logic            m_rvalid,
   output logic            m_rready,
   input  logic [XLEN-1:0] m_rdata,
   input  logic [1:0]      m_rresp
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [3:0]      req_wstrb;
   logic            aw_done, w_done, aw_done_next, w_done_next;
   logic            arvalid_next, rready_next, awvalid_next, wvalid_next, bready_next;
   logic            capture, rdata_load, err_load, err_value;
   logic            ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic            unused_addr_bits;

   // The bus is word-wide; the byte offset is carried by the strobe instead.
   assign unused_addr_bits = ^data_addr[1:0];

   assign ar_hs = m_arvalid & m_arready;
   assign r_hs  = m_rready & m_rvalid;
   assign aw_hs = m_awvalid & m_awready;
   assign w_hs  = m_wvalid & m_wready;
   // B is only taken once both AW and W are through (same-cycle counts).
   assign b_hs  = m_bready & m_bvalid & (aw_done | aw_hs) & (w_done | w_hs);

   assign data_stall = data_valid & (state != DONE);
   assign m_awaddr   = req_addr;
   assign m_araddr   = req_addr;
   assign m_wdata    = req_wdata;
   assign m_wstrb    = req_wstrb;

   // Next-state and next-cycle bus control decode.
   always_comb begin
      state_next   = state;
      arvalid_next = 1'b0;
      rready_next  = 1'b0;
      awvalid_next = 1'b0;
      wvalid_next  = 1'b0;
      bready_next  = 1'b0;
      aw_done_next = aw_done;
      w_done_next  = w_done;
      capture      = 1'b0;
      rdata_load   = 1'b0;
      err_load     = 1'b0;
      err_value    = 1'b0;
      case (state)
         IDLE: begin
            if (data_valid) begin
               capture      = 1'b1;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               if (data_wen) begin
                  state_next   = WRITE;
                  awvalid_next = 1'b1;
                  wvalid_next  = 1'b1;
                  bready_next  = 1'b1;
               end else begin
                  state_next   = RADDR;
                  arvalid_next = 1'b1;
               end
            end
         end
         RADDR: begin
            if (ar_hs) begin
               state_next  = RDATA;
               rready_next = 1'b1;
            end else begin
               arvalid_next = 1'b1;
            end
         end
         RDATA: begin
            if (r_hs) begin
               state_next = DONE;
               rdata_load = 1'b1;
               err_load   = 1'b1;
               err_value  = (m_rresp != 2'b00);
            end else begin
               rready_next = 1'b1;
            end
         end
         WRITE: begin
            aw_done_next = aw_done | aw_hs;
            w_done_next  = w_done | w_hs;
            if (b_hs) begin
               state_next   = DONE;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               err_load     = 1'b1;
               err_value    = (m_bresp != 2'b00);
            end else begin
               awvalid_next = ~aw_done_next;
               wvalid_next  = ~w_done_next;
               bready_next  = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Registered bus handshake controls and per-channel completion flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_arvalid <= 1'b0;
         m_rready  <= 1'b0;
         m_awvalid <= 1'b0;
         m_wvalid  <= 1'b0;
         m_bready  <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         m_arvalid <= arvalid_next;
         m_rready  <= rready_next;
         m_awvalid <= awvalid_next;
         m_wvalid  <= wvalid_next;
         m_bready  <= bready_next;
         aw_done   <= aw_done_next;
         w_done    <= w_done_next;
      end
   end

   // Captured request and response registers seen by the core.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr   <= '0;
         req_wdata  <= '0;
         req_wstrb  <= 4'b0000;
         data_rdata <= '0;
         data_err   <= 1'b0;
      end else begin
         if (capture) begin
            req_addr  <= {data_addr[XLEN-1:2], 2'b00};
            req_wdata <= data_wdata;
            req_wstrb <= data_wstrb;
         end
         if (rdata_load) data_rdata <= m_rdata;
         if (err_load)   data_err   <= err_value;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_axil_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_axil_bridge
//  Description : Scoreboard bench for lsu_axil_bridge with a configurable
//                AXI4-Lite slave and a word-array memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_axil_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_valid, data_wen;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_stall, data_err;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;

   always #5 clk = ~clk;

   lsu_axil_bridge #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .data_valid(data_valid), .data_wen(data_wen), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_stall(data_stall), .data_err(data_err),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
   );

   typedef struct {
      bit          wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      bit          err;
      int          stall;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_mem [16];
   logic [31:0] slave_mem [16];
   logic [31:0] last_rdata = 32'h0;

   // slave behaviour knobs, set by the driver before each request
   int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   bit          b_early = 1'b0;
   logic [1:0]  resp = 2'b00;
   int          ar_seen = 0, aw_seen = 0, w_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- AXI4-Lite slave (decides signals on the falling edge)
   int          ar_cnt, aw_cnt, w_cnt, r_timer, b_timer;
   bit          aw_got, w_got, b_sched, r_hs, b_hs;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [3:0]  wr_strb;

   initial begin
      m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      m_rdata = 0; m_rresp = 0; m_bresp = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_timer = 0; b_timer = 0;
      aw_got = 0; w_got = 0; b_sched = 0; r_hs = 0; b_hs = 0;
      rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_timer = 0; b_timer = 0;
            aw_got = 0; w_got = 0; b_sched = 0; r_hs = 0; b_hs = 0;
            continue;
         end
         if (r_hs) m_rvalid = 0;
         if (b_hs) begin
            m_bvalid = 0;
            for (int b = 0; b < 4; b++)
               if (wr_strb[b]) slave_mem[wr_addr[5:2]][8*b +: 8] = wr_data[8*b +: 8];
            aw_got = 0; w_got = 0; b_sched = 0;
         end
         if (r_timer > 0) begin
            r_timer--;
            if (r_timer == 0) begin
               m_rvalid = 1; m_rdata = slave_mem[rd_addr[5:2]]; m_rresp = resp;
            end
         end
         if (b_timer > 0) begin
            b_timer--;
            if (b_timer == 0) begin m_bvalid = 1; m_bresp = resp; end
         end
         m_arready = 0;
         if (m_arvalid) begin
            if (ar_cnt == ar_delay) begin
               m_arready = 1; ar_cnt = 0; ar_seen++; rd_addr = m_araddr;
               r_timer = r_delay + 1;
               if (sb.size() > 0) check("araddr", m_araddr, sb[0].addr);
            end else ar_cnt++;
         end
         m_awready = 0;
         if (m_awvalid) begin
            if (aw_cnt == aw_delay) begin
               m_awready = 1; aw_cnt = 0; aw_seen++; aw_got = 1; wr_addr = m_awaddr;
               if (sb.size() > 0) check("awaddr", m_awaddr, sb[0].addr);
            end else aw_cnt++;
         end
         m_wready = 0;
         if (m_wvalid) begin
            if (sb.size() > 0) check("wstrb_stable", 32'(m_wstrb), 32'(sb[0].wstrb));
            if (w_cnt == w_delay) begin
               m_wready = 1; w_cnt = 0; w_seen++; w_got = 1; wr_data = m_wdata; wr_strb = m_wstrb;
               if (sb.size() > 0) check("wdata", m_wdata, sb[0].wdata);
            end else w_cnt++;
         end
         if (aw_got && w_got && !b_sched) begin
            b_sched = 1;
            if (b_early) begin m_bvalid = 1; m_bresp = resp; end
            else b_timer = b_delay + 1;
         end
         r_hs = m_rvalid & m_rready;
         b_hs = m_bvalid & m_bready;
      end
   end

   // ---------------- monitor: a retire cycle is valid with stall low
   int   stall_cnt = 0;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_cnt = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
         end else if (data_valid && data_stall) begin
            stall_cnt++;
         end else if (data_valid) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL done_unexpected: got retire expected none");
            end else begin
               mon_e = sb.pop_front();
               check("data_err", 32'(data_err), 32'(mon_e.err));
               check("data_rdata", data_rdata, mon_e.rdata);
               check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
               check("ar_count", 32'(ar_seen), mon_e.wen ? 32'd0 : 32'd1);
               check("aw_count", 32'(aw_seen), mon_e.wen ? 32'd1 : 32'd0);
               check("w_count", 32'(w_seen), mon_e.wen ? 32'd1 : 32'd0);
               check("bus_idle_in_done", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 32'd0);
            end
            stall_cnt = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
         end
      end
   end

   // ---------------- driver with memory reference model
   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic do_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int ard, input int rd, input int awd,
                         input int wd, input int bd, input bit early, input logic [1:0] rsp,
                         input int gap);
      exp_t e;
      int   m;
      int   idx;
      int   budget;
      ar_delay = ard; r_delay = rd; aw_delay = awd; w_delay = wd; b_delay = bd;
      b_early = early; resp = rsp;
      idx = int'(addr[5:2]);
      e.wen = wen; e.addr = {addr[31:2], 2'b00}; e.wdata = wdata; e.wstrb = wstrb;
      e.err = (rsp != 2'b00);
      if (wen) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
         e.rdata = last_rdata;
         m = (awd > wd) ? awd : wd;
         e.stall = early ? (1 + m + 1) : (1 + m + 2 + bd);
      end else begin
         e.rdata = model_mem[idx];
         last_rdata = e.rdata;
         e.stall = 1 + (ard + 1) + (rd + 1);
      end
      sb.push_back(e);
      data_valid = 1; data_wen = wen; data_addr = addr; data_wdata = wdata; data_wstrb = wstrb;
      budget = 0;
      do begin @(negedge clk); budget++; end while (data_stall && budget < 200);
      if (data_stall) begin
         checks++; failures++;
         $display("FAIL txn_timeout: got stall after %0d cycles expected retire", budget);
         finish_run();
      end
      @(posedge clk); #1;
      if (gap > 0) begin
         data_valid = 0; data_addr = $urandom; data_wdata = $urandom;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   bit          rwen;
   logic [31:0] raddr;
   logic [1:0]  rrsp;
   int          wait_cnt;

   initial begin
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
         slave_mem[i] = model_mem[i];
      end
      model_mem[1] = 32'hDEAD_BEEF;
      slave_mem[1] = 32'hDEAD_BEEF;
      data_valid = 0; data_wen = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valids", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 32'd0);
      check("rst_rdata", data_rdata, 32'd0);
      check("rst_err", 32'(data_err), 32'd0);
      check("rst_bus_addr", m_araddr | m_awaddr | m_wdata | 32'(m_wstrb), 32'd0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      // zero-wait read, unaligned address
      do_txn(0, 32'h8000_0006, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
      // write, W accepted before AW
      do_txn(1, 32'h0000_0010, 32'h1234_1234, 4'b1100, 0, 0, 2, 0, 0, 0, 2'b00, 1);
      // AW, W and B all in one cycle
      do_txn(1, 32'h0000_0024, 32'hA5A5_5A5A, 4'b1111, 0, 0, 0, 0, 0, 1, 2'b00, 1);
      // error responses, then an OKAY clears the flag
      do_txn(0, 32'h0000_0010, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'b10, 0);
      do_txn(1, 32'h0000_0030, 32'hCAFE_F00D, 4'b0011, 0, 0, 1, 2, 1, 0, 2'b11, 0);
      do_txn(0, 32'h0000_0024, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
      // back-to-back load then store, slow address channels
      do_txn(0, 32'h8000_0004, 32'h0, 4'h0, 2, 0, 0, 0, 0, 0, 2'b00, 0);
      do_txn(1, 32'h8000_0014, 32'h0BAD_CAFE, 4'b1111, 0, 0, 2, 0, 0, 0, 2'b00, 1);

      // reset while waiting in the read data phase
      ar_delay = 0; r_delay = 6; resp = 2'b00; b_early = 0;
      data_valid = 1; data_wen = 0; data_addr = 32'h0000_0008;
      wait_cnt = 0;
      do begin @(negedge clk); wait_cnt++; end while (!m_rready && wait_cnt < 20);
      check("rready_before_reset", 32'(m_rready), 32'd1);
      #2 rst = 1;
      #1;
      check("async_rst_valids", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 32'd0);
      check("async_rst_rdata", data_rdata, 32'd0);
      check("async_rst_err", 32'(data_err), 32'd0);
      data_valid = 0;
      @(posedge clk); @(negedge clk); rst = 0;
      last_rdata = 32'h0;
      @(posedge clk); #1;
      do_txn(0, 32'h0000_0008, 32'h0, 4'h0, 1, 2, 0, 0, 0, 0, 2'b00, 1);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         rwen  = 1'($urandom_range(0, 1));
         raddr = ($urandom_range(0, 1) != 0 ? 32'h8000_0000 : 32'h0) | 32'($urandom_range(0, 63));
         rrsp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         do_txn(rwen, raddr, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                rrsp, $urandom_range(0, 2));
      end

      data_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      finish_run();
   end

endmodule
`default_nettype wire
